spi_max_value_readout_ctrl: RTL and testbench

Parametrised SPI read-out controller for the per-channel max-value cache. It decodes command opcodes from the SPI slave front end and snapshots the selected channel's cached peak (or every channel in turn) into a transmit word. It hands each word to the SPI transmitter over a valid/ready handshake. It sits between the SPI byte receiver, the max-value cache registers and the SPI shift-out logic.

---
 rtl/spi_max_value_readout_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_max_value_readout_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_max_value_readout_ctrl.sv
// SPI read-out controller: decodes opcodes, snapshots cached channel peaks and hands them to the transmitter.
// Optional clear-on-read of the cache entry is built when SPI_MVC_CLEAR_ON_READ_EN is defined.
module spi_max_value_readout_ctrl #(
    parameter int          NUM_CHANNELS   = 4,
    parameter int          DATA_WIDTH     = 16,
    parameter logic [7:0]  OP_CODE_BASE   = 8'h41,
    parameter logic [7:0]  OP_CODE_ALL    = 8'h40,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         SEL_W          = $clog2(NUM_CHANNELS + 1)
) (
    input  logic                               clk,
    input  logic                               reset_b,
    input  logic [7:0]                         op_code,
    input  logic                               op_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] max_values,
    input  logic                               tx_ready,
    output logic [DATA_WIDTH-1:0]              tx_data,
    output logic                               tx_valid,
    output logic [SEL_W-1:0]                   channel_sel,
    output logic [NUM_CHANNELS-1:0]            clear_req,
    output logic                               busy,
    output logic                               bad_op,
    output logic                               timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_all_q, mode_all_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   busy_q, busy_d;
    logic                   bad_op_q, bad_op_d;
    logic                   timeout_q, timeout_d;

    logic [8:0]             op_off;
    logic                   op_in_range;
    logic                   op_is_all;
    logic [DATA_WIDTH-1:0]  sel_value;

    // Nine-bit offset so opcodes below the base wrap to a large value and fall out of range.
    always_comb begin
        op_off      = {1'b0, op_code} - {1'b0, OP_CODE_BASE};
        op_in_range = (op_off < 9'(NUM_CHANNELS));
        op_is_all   = (op_code == OP_CODE_ALL);
    end

    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (sel_q == SEL_W'(k + 1)) begin
                sel_value = max_values[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_all_d = mode_all_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        timeout_d  = 1'b0;
        // Opcodes arriving mid-transfer are rejected without disturbing it.
        bad_op_d   = op_valid && !((state_q == IDLE) && (op_in_range || op_is_all));

        case (state_q)
            IDLE: begin
                if (op_valid && op_in_range) begin
                    sel_d      = op_off[SEL_W-1:0] + SEL_W'(1);
                    mode_all_d = 1'b0;
                    state_d    = CAPTURE;
                end else if (op_valid && op_is_all) begin
                    sel_d      = SEL_W'(1);
                    mode_all_d = 1'b1;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                tx_data_d  = sel_value;
                tx_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (mode_all_q && (sel_q < SEL_W'(NUM_CHANNELS))) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = CAPTURE;
                    end else begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d  = 1'b1;
                    tx_valid_d = 1'b0;
                    sel_d      = '0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= IDLE;
            mode_all_q <= 1'b0;
            cnt_q      <= '0;
            sel_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            bad_op_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_all_q <= mode_all_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            bad_op_q   <= bad_op_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef SPI_MVC_CLEAR_ON_READ_EN
    logic [NUM_CHANNELS-1:0] clear_req_q, clear_req_d;

    // Clear only on a completed handshake; an aborted transfer keeps its cached peak.
    always_comb begin
        clear_req_d = '0;
        if ((state_q == SEND) && tx_ready) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (sel_q == SEL_W'(k + 1)) begin
                    clear_req_d[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            clear_req_q <= '0;
        end else begin
            clear_req_q <= clear_req_d;
        end
    end

    assign clear_req = clear_req_q;
`else
    assign clear_req = '0;
`endif

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign channel_sel = sel_q;
    assign busy        = busy_q;
    assign bad_op      = bad_op_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_spi_max_value_readout_ctrl.sv
// Directed bench for spi_max_value_readout_ctrl: default 4x16 instance plus a 6x24 instance.
module tb_spi_max_value_readout_ctrl;

`ifdef SPI_MVC_CLEAR_ON_READ_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_b;
    logic [7:0]  op_code;
    logic        op_valid;
    logic [63:0] max_values;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic [2:0]  channel_sel;
    logic [3:0]  clear_req;
    logic        busy;
    logic        bad_op;
    logic        timeout;

    logic [7:0]   op_code6;
    logic         op_valid6;
    logic [143:0] max_values6;
    logic         tx_ready6;
    logic [23:0]  tx_data6;
    logic         tx_valid6;
    logic [2:0]   channel_sel6;
    logic [5:0]   clear_req6;
    logic         busy6;
    logic         bad_op6;
    logic         timeout6;

    int total;
    int bad;

    spi_max_value_readout_ctrl dut (
        .clk(clk), .reset_b(reset_b), .op_code(op_code), .op_valid(op_valid),
        .max_values(max_values), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .channel_sel(channel_sel), .clear_req(clear_req),
        .busy(busy), .bad_op(bad_op), .timeout(timeout)
    );

    spi_max_value_readout_ctrl #(.NUM_CHANNELS(6), .DATA_WIDTH(24)) dut6 (
        .clk(clk), .reset_b(reset_b), .op_code(op_code6), .op_valid(op_valid6),
        .max_values(max_values6), .tx_ready(tx_ready6), .tx_data(tx_data6),
        .tx_valid(tx_valid6), .channel_sel(channel_sel6), .clear_req(clear_req6),
        .busy(busy6), .bad_op(bad_op6), .timeout(timeout6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin : main
        logic [15:0] exp_all [4];
        logic [3:0]  exp_clr;
        int          n;

        total = 0;
        bad = 0;
        reset_b = 1'b0;
        op_code = 8'h00; op_valid = 1'b0; tx_ready = 1'b0;
        max_values = {16'h0044, 16'h1234, 16'h0022, 16'h0011};
        op_code6 = 8'h00; op_valid6 = 1'b0; tx_ready6 = 1'b0;
        max_values6 = {24'hABCDEF, 24'h555555, 24'h444444, 24'h333333, 24'h222222, 24'h111111};

        // Reset state
        step(); step();
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_sel", 32'(channel_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bad_op", 32'(bad_op), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_clear", 32'(clear_req), 32'h0);
        reset_b = 1'b1;
        step();

        // Single read of channel 3 with tx_ready high
        op_code = 8'h43; op_valid = 1'b1; tx_ready = 1'b1;
        step();
        op_valid = 1'b0;
        chk("s3_sel_e0", 32'(channel_sel), 32'd3);
        chk("s3_busy_e0", 32'(busy), 32'h1);
        chk("s3_txv_e0", 32'(tx_valid), 32'h0);
        step();
        chk("s3_txv_e1", 32'(tx_valid), 32'h1);
        chk("s3_data_e1", 32'(tx_data), 32'h1234);
        chk("s3_sel_e1", 32'(channel_sel), 32'd3);
        step();
        chk("s3_txv_e2", 32'(tx_valid), 32'h0);
        chk("s3_busy_e2", 32'(busy), 32'h0);
        chk("s3_sel_e2", 32'(channel_sel), 32'h0);
        chk("s3_clr_e2", 32'(clear_req), CLR_EN ? 32'h4 : 32'h0);
        step();
        chk("s3_clr_e3", 32'(clear_req), 32'h0);

        // Stream all channels with tx_ready toggling
        max_values = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        exp_all[0] = 16'h0011; exp_all[1] = 16'h0022;
        exp_all[2] = 16'h0033; exp_all[3] = 16'h0044;
        n = 0;
        op_code = 8'h40; op_valid = 1'b1; tx_ready = 1'b1;
        step();
        op_valid = 1'b0;
        chk("all_sel_e0", 32'(channel_sel), 32'd1);
        for (int cyc = 0; cyc < 40; cyc++) begin
            tx_ready = (cyc % 2 == 0);
            exp_clr = 4'b0000;
            if (tx_valid && tx_ready) begin
                if (n < 4) begin
                    chk("all_data", 32'(tx_data), 32'(exp_all[n]));
                    chk("all_sel", 32'(channel_sel), 32'(n + 1));
                    if (CLR_EN) exp_clr = 4'(1 << n);
                end
                n++;
            end
            step();
            chk("all_clr", 32'(clear_req), 32'(exp_clr));
            if (n >= 4 && !busy) break;
        end
        chk("all_count", 32'(n), 32'd4);
        chk("all_sel_end", 32'(channel_sel), 32'h0);
        chk("all_busy_end", 32'(busy), 32'h0);

        // Timeout with tx_ready held low
        tx_ready = 1'b0;
        op_code = 8'h42; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        chk("to_txv_e1", 32'(tx_valid), 32'h1);
        chk("to_data_e1", 32'(tx_data), 32'h0022);
        repeat (1023) step();
        chk("to_txv_pre", 32'(tx_valid), 32'h1);
        chk("to_pulse_pre", 32'(timeout), 32'h0);
        chk("to_busy_pre", 32'(busy), 32'h1);
        step();
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_txv", 32'(tx_valid), 32'h0);
        chk("to_sel", 32'(channel_sel), 32'h0);
        chk("to_clr", 32'(clear_req), 32'h0);
        step();
        chk("to_pulse_off", 32'(timeout), 32'h0);

        // tx_ready on the last allowed cycle: transfer wins
        op_code = 8'h42; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        repeat (1023) step();
        tx_ready = 1'b1;
        step();
        chk("late_timeout", 32'(timeout), 32'h0);
        chk("late_txv", 32'(tx_valid), 32'h0);
        chk("late_busy", 32'(busy), 32'h0);
        chk("late_clr", 32'(clear_req), CLR_EN ? 32'h2 : 32'h0);

        // Bad opcode in IDLE, then an opcode during SEND, with snapshot hold
        tx_ready = 1'b0;
        op_code = 8'h50; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("bad_idle", 32'(bad_op), 32'h1);
        chk("bad_idle_busy", 32'(busy), 32'h0);
        step();
        chk("bad_idle_off", 32'(bad_op), 32'h0);
        op_code = 8'h41; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("bad_first_ok", 32'(bad_op), 32'h0);
        step();
        chk("snap_data", 32'(tx_data), 32'h0011);
        max_values[15:0] = 16'hBEEF;
        op_code = 8'h41; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk("bad_send", 32'(bad_op), 32'h1);
        chk("bad_send_data", 32'(tx_data), 32'h0011);
        chk("bad_send_txv", 32'(tx_valid), 32'h1);
        chk("bad_send_sel", 32'(channel_sel), 32'd1);
        tx_ready = 1'b1;
        step();
        chk("bad_send_done", 32'(busy), 32'h0);
        chk("bad_send_off", 32'(bad_op), 32'h0);

        // Asynchronous reset mid-SEND in stream mode
        max_values = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        tx_ready = 1'b0;
        op_code = 8'h40; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        chk("ar_txv_pre", 32'(tx_valid), 32'h1);
        reset_b = 1'b0;
        #1;
        chk("ar_txv", 32'(tx_valid), 32'h0);
        chk("ar_data", 32'(tx_data), 32'h0);
        chk("ar_sel", 32'(channel_sel), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_clr", 32'(clear_req), 32'h0);
        step();
        reset_b = 1'b1;
        step();
        op_code = 8'h44; op_valid = 1'b1; tx_ready = 1'b1;
        step();
        op_valid = 1'b0;
        chk("ar_next_sel", 32'(channel_sel), 32'd4);
        step();
        chk("ar_next_data", 32'(tx_data), 32'h0044);
        chk("ar_next_txv", 32'(tx_valid), 32'h1);
        step();
        chk("ar_next_idle", 32'(busy), 32'h0);
        chk("ar_next_clr", 32'(clear_req), CLR_EN ? 32'h8 : 32'h0);

        // Six-channel, 24-bit instance
        op_code6 = 8'h46; op_valid6 = 1'b1; tx_ready6 = 1'b1;
        step();
        op_valid6 = 1'b0;
        chk("w6_sel", 32'(channel_sel6), 32'd6);
        step();
        chk("w6_data", 32'(tx_data6), 32'h00ABCDEF);
        chk("w6_txv", 32'(tx_valid6), 32'h1);
        step();
        chk("w6_idle", 32'(busy6), 32'h0);
        chk("w6_clr", 32'(clear_req6), CLR_EN ? 32'h20 : 32'h0);
        op_code6 = 8'h47; op_valid6 = 1'b1;
        step();
        op_valid6 = 1'b0;
        chk("w6_bad", 32'(bad_op6), 32'h1);
        chk("w6_bad_busy", 32'(busy6), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
